// File: rtl/branch_resolve.sv
// Execute-stage branch resolution: decodes the comparator flags into a taken
// decision, issues a registered fetch redirect on mispredict and holds a squash window.
module branch_resolve #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic             ex_is_jal,
  input  logic             ex_is_jalr,
  input  logic [2:0]       ex_funct3,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      ex_target,
  input  logic             ex_pred_taken,
  input  logic             BrEq,
  input  logic             BrLt,
  output logic             BrUn,
  output logic             redirect_valid,
  input  logic             redirect_ready,
  output logic [31:0]      redirect_pc,
  output logic             stall_o,
  output logic             flush_o,
  output logic             misalign_o,
  output logic             illegal_br_o,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mp_count
);

  localparam int FC_W = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0] FLUSH_LOAD =
    (FLUSH_CYCLES > 0) ? FC_W'(FLUSH_CYCLES - 1) : {FC_W{1'b0}};

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  state_t            state_r;
  logic [FC_W-1:0]   flush_cnt_r;

  logic              cond_taken_s;
  logic              taken_s;
  logic [31:0]       target_s;
  logic              illegal_s;
  logic              misalign_s;
  logic              mispredict_s;
  logic              count_br_s;
  logic [31:0]       new_pc_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign BrUn = ex_funct3[1];

  // Outcome decode; jalr outranks jal, which outranks a conditional branch.
  always_comb begin
    cond_taken_s = 1'b0;
    taken_s      = 1'b0;
    target_s     = ex_target;
    case (ex_funct3)
      3'b000:          cond_taken_s = BrEq;
      3'b001:          cond_taken_s = ~BrEq;
      3'b100, 3'b110:  cond_taken_s = BrLt;
      3'b101, 3'b111:  cond_taken_s = ~BrLt;
      default:         cond_taken_s = 1'b0;
    endcase
    if (ex_is_jalr) begin
      taken_s  = 1'b1;
      target_s = {ex_target[31:1], 1'b0};
    end else if (ex_is_jal) begin
      taken_s  = 1'b1;
    end else if (ex_is_branch) begin
      taken_s  = cond_taken_s;
    end else begin
      taken_s  = 1'b0;
    end
    illegal_s    = ex_is_branch && !ex_is_jal && !ex_is_jalr && (ex_funct3[2:1] == 2'b01);
    misalign_s   = taken_s && (target_s[1:0] != 2'b00);
    // A faulting instruction never redirects, whatever the prediction said.
    mispredict_s = !illegal_s && !misalign_s && ((taken_s != ex_pred_taken) || ex_is_jalr);
    count_br_s   = ex_is_branch && !ex_is_jal && !ex_is_jalr && !illegal_s && !misalign_s;
    new_pc_s     = taken_s ? target_s : (ex_pc + 32'd4);
  end

  // Redirect/flush FSM with registered outputs and saturating counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      flush_cnt_r    <= {FC_W{1'b0}};
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'd0;
      stall_o        <= 1'b0;
      flush_o        <= 1'b0;
      misalign_o     <= 1'b0;
      illegal_br_o   <= 1'b0;
      br_count       <= {CNT_W{1'b0}};
      mp_count       <= {CNT_W{1'b0}};
    end else begin
      misalign_o   <= 1'b0;
      illegal_br_o <= 1'b0;
      case (state_r)
        IDLE: begin
          stall_o <= 1'b0;
          flush_o <= 1'b0;
          if (ex_valid) begin
            misalign_o   <= misalign_s;
            illegal_br_o <= illegal_s;
            if (count_br_s) begin
              br_count <= sat_inc(br_count);
            end
            if (mispredict_s) begin
              redirect_pc    <= new_pc_s;
              redirect_valid <= 1'b1;
              stall_o        <= 1'b1;
              mp_count       <= sat_inc(mp_count);
              state_r        <= REDIRECT;
            end
          end
        end
        REDIRECT: begin
          if (redirect_ready) begin
            redirect_valid <= 1'b0;
            if (FLUSH_CYCLES > 0) begin
              flush_cnt_r <= FLUSH_LOAD;
              flush_o     <= 1'b1;
              state_r     <= FLUSH;
            end else begin
              stall_o <= 1'b0;
              state_r <= IDLE;
            end
          end
        end
        FLUSH: begin
          flush_o <= 1'b1;
          stall_o <= 1'b1;
          if (flush_cnt_r == {FC_W{1'b0}}) begin
            flush_o <= 1'b0;
            stall_o <= 1'b0;
            state_r <= IDLE;
          end else begin
            flush_cnt_r <= flush_cnt_r - {{(FC_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          redirect_valid <= 1'b0;
          stall_o        <= 1'b0;
          flush_o        <= 1'b0;
          state_r        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Directed self-checking bench for branch_resolve (4-bit counters to reach saturation quickly).
module tb_branch_resolve;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ex_valid = 1'b0;
  logic          ex_is_branch = 1'b0;
  logic          ex_is_jal = 1'b0;
  logic          ex_is_jalr = 1'b0;
  logic [2:0]    ex_funct3 = 3'b000;
  logic [31:0]   ex_pc = 32'd0;
  logic [31:0]   ex_target = 32'd0;
  logic          ex_pred_taken = 1'b0;
  logic          BrEq = 1'b0;
  logic          BrLt = 1'b0;
  logic          BrUn;
  logic          redirect_valid;
  logic          redirect_ready = 1'b0;
  logic [31:0]   redirect_pc;
  logic          stall_o;
  logic          flush_o;
  logic          misalign_o;
  logic          illegal_br_o;
  logic [CW-1:0] br_count;
  logic [CW-1:0] mp_count;

  int checks = 0;
  int errors = 0;

  branch_resolve #(.FLUSH_CYCLES(2), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
    .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr), .ex_funct3(ex_funct3),
    .ex_pc(ex_pc), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
    .BrEq(BrEq), .BrLt(BrLt), .BrUn(BrUn), .redirect_valid(redirect_valid),
    .redirect_ready(redirect_ready), .redirect_pc(redirect_pc), .stall_o(stall_o),
    .flush_o(flush_o), .misalign_o(misalign_o), .illegal_br_o(illegal_br_o),
    .br_count(br_count), .mp_count(mp_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_instr(input logic br, input logic jal, input logic jalr, input logic [2:0] f3,
                           input logic [31:0] pc, input logic [31:0] tgt, input logic pred,
                           input logic eq, input logic lt);
    ex_valid = 1'b1; ex_is_branch = br; ex_is_jal = jal; ex_is_jalr = jalr;
    ex_funct3 = f3; ex_pc = pc; ex_target = tgt; ex_pred_taken = pred; BrEq = eq; BrLt = lt;
  endtask

  task automatic drain_redirect();
    ex_valid = 1'b0;
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    // Reset state
    tick(); tick();
    rst = 1'b0;
    chk("rst_rv", redirect_valid, 32'd0);
    chk("rst_pc", redirect_pc, 32'd0);
    chk("rst_stall", stall_o, 32'd0);
    chk("rst_flush", flush_o, 32'd0);
    chk("rst_br", br_count, 32'd0);
    chk("rst_mp", mp_count, 32'd0);

    // BEQ taken, predicted not taken
    set_instr(1'b1, 1'b0, 1'b0, 3'b000, 32'h100, 32'h140, 1'b0, 1'b1, 1'b0);
    tick();
    ex_valid = 1'b0;
    chk("beq_rv", redirect_valid, 32'd1);
    chk("beq_pc", redirect_pc, 32'h140);
    chk("beq_stall", stall_o, 32'd1);
    chk("beq_mp", mp_count, 32'd1);
    chk("beq_br", br_count, 32'd1);
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
    chk("beq_hs_rv", redirect_valid, 32'd0);
    chk("beq_fl0", flush_o, 32'd1);
    tick();
    chk("beq_fl1", flush_o, 32'd1);
    tick();
    chk("beq_fl2", flush_o, 32'd0);
    chk("beq_stall_end", stall_o, 32'd0);

    // BGE not taken, predicted taken; ready held low, ex_valid ignored while stalled
    set_instr(1'b1, 1'b0, 1'b0, 3'b101, 32'h200, 32'h280, 1'b1, 1'b0, 1'b1);
    #1;
    chk("bge_brun", BrUn, 32'd0);
    tick();
    chk("bge_rv", redirect_valid, 32'd1);
    chk("bge_pc", redirect_pc, 32'h204);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bge_hold_rv", redirect_valid, 32'd1);
      chk("bge_hold_pc", redirect_pc, 32'h204);
    end
    chk("bge_mp", mp_count, 32'd2);
    chk("bge_br", br_count, 32'd2);
    ex_valid = 1'b0;
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
    chk("bge_hs_rv", redirect_valid, 32'd0);
    chk("bge_fl0", flush_o, 32'd1);
    chk("bge_st0", stall_o, 32'd1);
    tick();
    chk("bge_fl1", flush_o, 32'd1);
    tick();
    chk("bge_fl2", flush_o, 32'd0);
    chk("bge_st2", stall_o, 32'd0);

    // BLTU taken and correctly predicted
    set_instr(1'b1, 1'b0, 1'b0, 3'b110, 32'h300, 32'h500, 1'b1, 1'b0, 1'b1);
    #1;
    chk("bltu_brun", BrUn, 32'd1);
    tick();
    ex_valid = 1'b0;
    chk("bltu_rv", redirect_valid, 32'd0);
    chk("bltu_stall", stall_o, 32'd0);
    chk("bltu_br", br_count, 32'd3);
    chk("bltu_mp", mp_count, 32'd2);

    // JALR always mispredicts, bit 0 of target cleared
    set_instr(1'b0, 1'b0, 1'b1, 3'b000, 32'h310, 32'h301, 1'b1, 1'b0, 1'b0);
    tick();
    chk("jalr_rv", redirect_valid, 32'd1);
    chk("jalr_pc", redirect_pc, 32'h300);
    chk("jalr_mp", mp_count, 32'd3);
    chk("jalr_br", br_count, 32'd3);
    drain_redirect();
    chk("jalr_stall_end", stall_o, 32'd0);

    // JAL to a misaligned target
    set_instr(1'b0, 1'b1, 1'b0, 3'b000, 32'h400, 32'h402, 1'b1, 1'b0, 1'b0);
    tick();
    ex_valid = 1'b0;
    chk("jal_mis", misalign_o, 32'd1);
    chk("jal_rv", redirect_valid, 32'd0);
    chk("jal_mp", mp_count, 32'd3);
    tick();
    chk("jal_mis_pulse", misalign_o, 32'd0);

    // Reserved branch funct3
    set_instr(1'b1, 1'b0, 1'b0, 3'b010, 32'h410, 32'h450, 1'b1, 1'b1, 1'b1);
    tick();
    ex_valid = 1'b0;
    chk("ill_pulse", illegal_br_o, 32'd1);
    chk("ill_rv", redirect_valid, 32'd0);
    chk("ill_br", br_count, 32'd3);
    chk("ill_mp", mp_count, 32'd3);
    tick();
    chk("ill_pulse_end", illegal_br_o, 32'd0);

    // Branch+JAL flagged together: JAL wins, then reset mid-REDIRECT
    set_instr(1'b1, 1'b1, 1'b0, 3'b000, 32'h5F0, 32'h600, 1'b0, 1'b0, 1'b0);
    tick();
    ex_valid = 1'b0;
    chk("prio_rv", redirect_valid, 32'd1);
    chk("prio_pc", redirect_pc, 32'h600);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_rv", redirect_valid, 32'd0);
    chk("mrst_pc", redirect_pc, 32'd0);
    chk("mrst_stall", stall_o, 32'd0);
    chk("mrst_flush", flush_o, 32'd0);
    chk("mrst_br", br_count, 32'd0);
    chk("mrst_mp", mp_count, 32'd0);
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
    chk("idle_ready_flush", flush_o, 32'd0);
    chk("idle_ready_stall", stall_o, 32'd0);

    // 20 mispredicts saturate a 4-bit counter at 15
    for (int n = 0; n < 20; n++) begin
      set_instr(1'b0, 1'b0, 1'b1, 3'b000, 32'h700, 32'h800, 1'b1, 1'b0, 1'b0);
      tick();
      drain_redirect();
    end
    chk("sat_mp", mp_count, 32'd15);
    chk("sat_br", br_count, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- Execute-stage branch resolution unit, directly downstream of the branch comparator.
- Drives the comparator's unsigned-select input, consumes its equal/less-than flags and the precomputed target, and decides the branch outcome.
- On a mispredict, issues a registered PC redirect to fetch over a valid/ready handshake, then holds a squash window over younger instructions.
- Keeps saturating branch and mispredict counters for performance monitoring.

Parameters:
- FLUSH_CYCLES, 2, cycles flush_o is held after a redirect handshake; 0 means no flush window.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock, all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- ex_valid  in  1  EX-stage instruction valid
- ex_is_branch  in  1  conditional branch (BEQ/BNE/BLT/BGE/BLTU/BGEU)
- ex_is_jal  in  1  JAL
- ex_is_jalr  in  1  JALR
- ex_funct3  in  3  branch funct3
- ex_pc  in  32  PC of the EX instruction
- ex_target  in  32  computed target (pc+imm, or rs1+imm for JALR)
- ex_pred_taken  in  1  fetch prediction for this instruction
- BrEq  in  1  comparator equal flag
- BrLt  in  1  comparator less-than flag
- BrUn  out  1  comparator unsigned select, combinational, equal to ex_funct3[1]
- redirect_valid  out  1  redirect request to fetch
- redirect_ready  in  1  fetch accepts the redirect
- redirect_pc  out  32  new fetch PC
- stall_o  out  1  freeze EX and the stages upstream of it
- flush_o  out  1  squash younger instructions
- misalign_o  out  1  one-cycle pulse: taken target not word-aligned
- illegal_br_o  out  1  one-cycle pulse: funct3 is 010 or 011 with ex_is_branch set
- br_count  out  CNT_W  resolved conditional branches
- mp_count  out  CNT_W  mispredicts

Behaviour:
- Reset (synchronous, rst high at a clock edge):
  - State goes to IDLE.
  - redirect_valid, redirect_pc, stall_o, flush_o, misalign_o, illegal_br_o, br_count and mp_count all go to 0.
  - Reset applied in any state, mid-handshake included, abandons the operation.
- Taken decode (conditional branch):
  - 000: BrEq
  - 001: !BrEq
  - 100 and 110: BrLt
  - 101 and 111: !BrLt
  - 010 and 011: not taken, pulse illegal_br_o, no redirect.
- JAL is always taken.
- JALR is always taken and always treated as a mispredict, since target prediction is unsupported.
- Effective target:
  - JALR: {ex_target[31:1],1'b0}.
  - All others: ex_target.
- Alignment check:
  - If the instruction is taken and target[1:0] is not 0, pulse misalign_o the next cycle.
  - No redirect is issued and no counter changes.
- Mispredict:
  - Condition: actual_taken != ex_pred_taken, or JALR.
  - redirect_pc = actual taken ? target : ex_pc+4, computed modulo 2^32.
- FSM has three states: IDLE, REDIRECT, FLUSH.
- IDLE:
  - stall_o=0 and flush_o=0.
  - On ex_valid with a mispredict, at the next edge: latch redirect_pc, set redirect_valid=1 and stall_o=1, and enter REDIRECT.
  - Latency from sampling ex_valid to redirect_valid is 1 cycle.
- REDIRECT:
  - redirect_valid and redirect_pc are held stable until redirect_ready is high.
  - On the handshake edge, clear redirect_valid.
  - If FLUSH_CYCLES > 0: enter FLUSH with the counter at FLUSH_CYCLES-1 and flush_o=1.
  - Otherwise: return to IDLE and clear stall_o.
- FLUSH:
  - flush_o=1 and stall_o=1.
  - Counter decrements each cycle.
  - At counter 0, the next edge returns to IDLE and clears flush_o and stall_o.
  - flush_o is therefore high for exactly FLUSH_CYCLES cycles.
- Outside IDLE, ex_valid is ignored because upstream is stalled.
- Counters:
  - br_count increments when IDLE sees ex_valid with ex_is_branch and a legal funct3.
  - mp_count increments when IDLE sees any accepted mispredict.
  - Both saturate at all-ones and do not wrap.
- Simultaneous flags: ex_is_branch with ex_is_jal or ex_is_jalr is a decode error. Priority is jalr > jal > branch.
- redirect_ready asserted while in IDLE or FLUSH is ignored.

Test Plan:
- BEQ, BrEq=1, pred 0, pc=0x100, target=0x140 → 1 cycle later: redirect_valid=1, redirect_pc=0x140, stall_o=1; mp_count=1, br_count=1.
- BGE, BrLt=1, pred 1, pc=0x200 → redirect_pc=0x204. Hold redirect_ready=0 for 3 cycles: redirect_pc stays stable. After ready, flush_o is high exactly 2 cycles, then stall_o=0.
- BLTU, funct3=110 → BrUn=1. BrLt=1, pred 1 → no redirect, br_count increments, mp_count unchanged.
- JALR target=0x301, pred 1 → redirect_pc=0x300. JAL target=0x402 → misalign_o pulses, no redirect.
- funct3=010 with ex_is_branch → illegal_br_o pulses, counters unchanged. rst asserted during REDIRECT → next cycle all outputs are 0 and state is IDLE.
- Preload mp_count near all-ones (or use CNT_W=4) and run 20 mispredicts → mp_count saturates at all-ones.
